// File: rtl/raster_to_bitplane_pkg.sv
// Shared definitions for the raster/bitplane converters: pixel-format codes,
// converter FSM encoding and per-format packing helpers.
package raster_to_bitplane_pkg;

    // Same format codes as bitplane_to_raster so both directions agree on video_mode.
    typedef enum logic [3:0] {
        MODE_1BPP  = 4'd1,
        MODE_2BPP  = 4'd2,
        MODE_4BPP  = 4'd3,
        MODE_8BPP  = 4'd4,
        MODE_16BPP = 4'd5
    } video_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PACK  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    function automatic logic mode_valid(input logic [3:0] mode);
        return (mode >= 4'd1) && (mode <= 4'd5);
    endfunction

    // Bits each pixel contributes to the low byte (16bpp packs its low byte like 8bpp).
    function automatic logic [3:0] mode_bpp(input logic [3:0] mode);
        case (mode)
            4'd1:    return 4'd1;
            4'd2:    return 4'd2;
            4'd3:    return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

    function automatic logic [3:0] mode_ppb(input logic [3:0] mode);
        case (mode)
            4'd1:    return 4'd8;
            4'd2:    return 4'd4;
            4'd3:    return 4'd2;
            default: return 4'd1;
        endcase
    endfunction

endpackage

// File: rtl/raster_to_bitplane_pixel_packer.sv
// MSB-first pixel accumulator: merges each accepted pixel into the current byte
// and flags the pixel that completes it.
module pixel_packer
    import raster_to_bitplane_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear_i,
    input  logic       load_i,
    input  logic [3:0] mode_i,
    input  logic [7:0] pixel_i,
    output logic       byte_full_o,
    output logic       has_partial_o,
    output logic [7:0] packed_byte_o
);

    logic [7:0] acc_q, acc_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] bpp;
    logic [3:0] ppb;
    logic [3:0] used_bits;
    logic [3:0] shamt;
    logic [7:0] mask;
    logic [7:0] merged;

    always_comb begin
        bpp       = mode_bpp(mode_i);
        ppb       = mode_ppb(mode_i);
        mask      = 8'hFF >> (4'd8 - bpp);
        // Slot k occupies bits [8-bpp*k-1 : 8-bpp*(k+1)]; unused low bits stay zero.
        used_bits = 4'(bpp * (cnt_q + 4'd1));
        shamt     = 4'd8 - used_bits;
        merged    = acc_q | ((pixel_i & mask) << shamt);

        byte_full_o   = load_i && ((cnt_q + 4'd1) == ppb);
        has_partial_o = (cnt_q != 4'd0);
        packed_byte_o = load_i ? merged : acc_q;

        acc_d = acc_q;
        cnt_d = cnt_q;
        if (clear_i) begin
            acc_d = 8'h00;
            cnt_d = 4'd0;
        end else if (load_i) begin
            if (byte_full_o) begin
                acc_d = 8'h00;
                cnt_d = 4'd0;
            end else begin
                acc_d = merged;
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= 8'h00;
            cnt_q <= 4'd0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/raster_to_bitplane.sv
// Converts a stream of raster pixels into packed byte/word memory writes for
// one line at a time, with a held-until-acknowledged write port.
module raster_to_bitplane
    import raster_to_bitplane_pkg::*;
#(
    parameter int ADDR_SIZE = 20
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [3:0]           video_mode,
    input  logic [ADDR_SIZE-1:0] base_addr,
    input  logic [9:0]           line_len,
    input  logic                 pix_valid,
    output logic                 pix_ready,
    input  logic [7:0]           pixel_in,
    input  logic [7:0]           pixel_in_h,
    output logic                 wr_ena,
    input  logic                 wr_ack,
    output logic [ADDR_SIZE-1:0] wr_addr,
    output logic [15:0]          wr_data,
    output logic                 wr_16bit,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           dbg_state
);

    // Handshakes: a pixel moves when pix_valid && pix_ready at a rising edge; a
    // write moves when wr_ena && wr_ack, and wr_ena/wr_addr/wr_data hold until then.
    state_e                 state_q, state_d;
    logic [3:0]             mode_q, mode_d;
    logic [ADDR_SIZE-1:0]   addr_q, addr_d;
    logic [9:0]             remain_q, remain_d;
    logic                   wr_ena_q, wr_ena_d;
    logic [ADDR_SIZE-1:0]   wr_addr_q, wr_addr_d;
    logic [15:0]            wr_data_q, wr_data_d;
    logic                   wr_16bit_q, wr_16bit_d;
    logic                   done_q, done_d;

    logic                   slot_free;
    logic                   accept;
    logic                   start_ok;
    logic                   is_16;
    logic [ADDR_SIZE-1:0]   step;
    logic                   byte_full;
    logic                   has_partial;
    logic [7:0]             packed_byte;

    assign slot_free = !wr_ena_q || wr_ack;
    assign pix_ready = !reset && (state_q == ST_PACK) && slot_free;
    assign accept    = pix_valid && pix_ready;
    assign start_ok  = start && mode_valid(video_mode) && (line_len != 10'd0);
    assign is_16     = (mode_q == MODE_16BPP);
    assign step      = is_16 ? ADDR_SIZE'(2) : ADDR_SIZE'(1);

    pixel_packer u_packer (
        .clk           (clk),
        .reset         (reset),
        .clear_i       ((state_q == ST_IDLE) && start_ok),
        .load_i        (accept),
        .mode_i        (mode_q),
        .pixel_i       (pixel_in),
        .byte_full_o   (byte_full),
        .has_partial_o (has_partial),
        .packed_byte_o (packed_byte)
    );

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        addr_d     = addr_q;
        remain_d   = remain_q;
        wr_ena_d   = wr_ena_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        wr_16bit_d = wr_16bit_q;
        done_d     = 1'b0;

        if (wr_ena_q && wr_ack) begin
            wr_ena_d   = 1'b0;
            wr_16bit_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    mode_d   = video_mode;
                    addr_d   = base_addr;
                    remain_d = line_len;
                    state_d  = ST_PACK;
                end else if (start) begin
                    done_d = 1'b1;
                end
            end
            ST_PACK: begin
                if (accept) begin
                    remain_d = remain_q - 10'd1;
                    // A retiring write and a completing byte overlap: the new write
                    // replaces it on the next edge without a gap.
                    if (byte_full) begin
                        wr_ena_d   = 1'b1;
                        wr_addr_d  = addr_q;
                        wr_data_d  = is_16 ? {pixel_in_h, packed_byte} : {8'h00, packed_byte};
                        wr_16bit_d = is_16;
                        addr_d     = addr_q + step;
                    end
                    if (remain_q == 10'd1) begin
                        state_d = byte_full ? ST_DRAIN : ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                if (slot_free) begin
                    if (has_partial) begin
                        wr_ena_d   = 1'b1;
                        wr_addr_d  = addr_q;
                        wr_data_d  = {8'h00, packed_byte};
                        wr_16bit_d = 1'b0;
                        addr_d     = addr_q + step;
                    end
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (slot_free) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            mode_q     <= 4'd0;
            addr_q     <= '0;
            remain_q   <= 10'd0;
            wr_ena_q   <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= 16'h0000;
            wr_16bit_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            addr_q     <= addr_d;
            remain_q   <= remain_d;
            wr_ena_q   <= wr_ena_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            wr_16bit_q <= wr_16bit_d;
            done_q     <= done_d;
        end
    end

    assign wr_ena    = wr_ena_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign wr_16bit  = wr_16bit_q;
    assign done      = done_q;
    assign busy      = (state_q != ST_IDLE);
    assign dbg_state = state_q;

endmodule

// File: doc/raster_to_bitplane.md
RASTER_TO_BITPLANE -- requirements
Module: raster_to_bitplane

Interface
REQ-001 SHALL have parameter ADDR_SIZE, default 20: width of the write address.
REQ-002 SHALL have port clk, input, 1: the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1: one-cycle pulse that begins a line; honoured only in IDLE.
REQ-005 SHALL have port video_mode, input, 4: pixel format, sampled on start (1=1bpp, 2=2bpp, 3=4bpp, 4=8bpp, 5=16bpp; all other values are invalid).
REQ-006 SHALL have port base_addr, input, ADDR_SIZE: byte address of the first write, sampled on start.
REQ-007 SHALL have port line_len, input, 10: number of pixels in the line, sampled on start.
REQ-008 SHALL have port pix_valid, input, 1: pixel_in and pixel_in_h are valid.
REQ-009 SHALL have port pix_ready, output, 1: the block accepts a pixel when pix_valid and pix_ready are both high.
REQ-010 SHALL have ports pixel_in and pixel_in_h, input, 8 each: pixel low and high bytes; pixel_in_h is used only in 16bpp mode.
REQ-011 SHALL have port wr_ena, output, 1: write request, held high until acknowledged.
REQ-012 SHALL have port wr_ack, input, 1: memory accepts the write in this cycle.
REQ-013 SHALL have ports wr_addr, output, ADDR_SIZE; wr_data, output, 16; wr_16bit, output, 1 (write is a 16-bit word).
REQ-014 SHALL have ports busy, output, 1, and done, output, 1 (one-cycle pulse when the line is complete).

Function
REQ-015 SHALL implement the states IDLE, PACK, FLUSH and DRAIN.
REQ-016 IDLE -> PACK on start when video_mode is valid (1-5) and line_len is nonzero.
REQ-017 IDLE on start with an invalid video_mode or line_len=0 SHALL stay in IDLE and pulse done on the next cycle, with no writes.
REQ-018 SHALL pack pixels MSB-first, so the first pixel of a byte occupies the top bits:
- 1bpp: 8 pixels per byte, bit 7-k = pixel_in[0].
- 2bpp: 4 pixels per byte, bits [7-2k:6-2k] = pixel_in[1:0].
- 4bpp: 2 pixels per byte, first pixel in [7:4], second in [3:0] = pixel_in[3:0].
- 8bpp: 1 pixel per byte = pixel_in.
- 16bpp: wr_data = {pixel_in_h, pixel_in}.
REQ-019 When the accepted pixel completes a byte or word, SHALL assert wr_ena on the next cycle with the packed data and the current address.
REQ-020 SHALL hold wr_ena, wr_addr and wr_data stable until wr_ack.
REQ-021 After each acknowledged write, SHALL advance the address by 1 byte in modes 1-4 and by 2 in mode 5; the address wraps modulo 2^ADDR_SIZE.
REQ-022 pix_ready SHALL be 1 only in PACK, and only when no write is pending or wr_ack is high in the same cycle.
REQ-023 When a pixel completes a byte in the same cycle that wr_ack retires the previous write, SHALL present the new write on the next cycle with no bubble.
REQ-024 After line_len pixels are accepted: if a partial byte remains, SHALL go to FLUSH; otherwise SHALL go to DRAIN.
REQ-025 In FLUSH, SHALL write the partial byte with the unused low bits padded with zero, then go to DRAIN.
REQ-026 DRAIN SHALL wait for the final wr_ack, then pulse done for 1 cycle and return to IDLE.
REQ-027 busy SHALL be high in every state except IDLE.
REQ-028 wr_16bit SHALL be 1 only for mode-5 writes; for 8-bit writes wr_data[15:8] SHALL be 0.
REQ-029 start received while busy SHALL be ignored.

Reset
REQ-030 reset SHALL force IDLE from any state, including mid-line, and discard any pending partial data.
REQ-031 reset SHALL drive wr_ena, pix_ready, busy, done and wr_16bit to 0, and wr_addr and wr_data to 0.
REQ-032 A write pending when reset asserts SHALL be dropped and SHALL NOT be re-issued after reset.

Structure
REQ-033 The mode codes (1-5) and the state encoding SHALL live in a shared package alongside the bitplane_to_raster mode definitions.
REQ-034 SHALL use one sub-module, pixel_packer: a shift/accumulate register with a pixel counter, producing byte_full and packed_byte.
REQ-035 The FSM, address counter and write handshake SHALL stay at top level.

Verification
REQ-036 1bpp, base_addr=0x100, line_len=16, pixel_in[0] pattern 1,0,1,0...: writes 0xAA to 0x100 and 0xAA to 0x101, then done.
REQ-037 4bpp, line_len=3, pixels 0x3, 0xC, 0x7, wr_ack always high: writes 0x3C, then 0x70 (FLUSH padding), then done.
REQ-038 16bpp, base_addr=0x0FFFFE, two pixels {0x12,0x34} and {0x56,0x78}: writes 0x1234 to 0xFFFFE and 0x5678 to 0x00000 (wrap), with wr_16bit=1.
REQ-039 8bpp with wr_ack held low for 5 cycles: pix_ready=0 and wr_ena/wr_addr/wr_data stable throughout; no pixel is lost.
REQ-040 reset asserted mid-line after 3 of 8 pixels in 1bpp mode: next cycle IDLE with all outputs 0; a new start then produces correct output with no residue.
REQ-041 start with video_mode=0 or line_len=0: no wr_ena, and done pulses one cycle later.
